// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - EX-stage to mul/div unit request and HI/LO bus
//
// Purpose: groups the request, flush, MTHI/MTLO and result signals between
//   the pipeline (master) and the mul/div controller (slave).
// Signals: start, func[4:0], sign, source_a[31:0], source_b[31:0], flush,
//   hi_write, lo_write, hi_write_data[31:0], lo_write_data[31:0]  (to unit)
//   stall, busy, hi[31:0], lo[31:0]                               (from unit)
// Also supplies the FUNC_MUL / FUNC_DIV encodings unless defined elsewhere.

`ifndef FUNC_MUL
`define FUNC_MUL 5'h18
`endif
`ifndef FUNC_DIV
`define FUNC_DIV 5'h1a
`endif

interface muldiv_ctrl_if;
  logic        start;
  logic [4:0]  func;
  logic        sign;
  logic [31:0] source_a;
  logic [31:0] source_b;
  logic        flush;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] hi_write_data;
  logic [31:0] lo_write_data;
  logic        stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, func, sign, source_a, source_b, flush,
           hi_write, lo_write, hi_write_data, lo_write_data,
    input  stall, busy, hi, lo
  );

  modport slave (
    input  start, func, sign, source_a, source_b, flush,
           hi_write, lo_write, hi_write_data, lo_write_data,
    output stall, busy, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative multiply/divide unit owning the HI/LO registers
//
// Purpose: accepts MUL/DIV requests from EX, runs a 32-step shift-add
//   multiply or restoring divide on operand magnitudes, fixes up signs and
//   commits {hi, lo} on the edge leaving DONE. Handles MTHI/MTLO and flush.
// Ports: clk, rst (async, active high); bus (muldiv_ctrl_if.slave).
// Config: define MULDIV_FAST_MUL_EN for a single-cycle 64-bit multiply.

module muldiv_ctrl (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] opnd_q;    // multiplicand (MUL) or divisor (DIV) magnitude
  logic [31:0] acc_q;     // product high half / partial remainder
  logic [31:0] shf_q;     // multiplier -> product low half / dividend -> quotient
  logic [31:0] hi_q, lo_q;
  logic        is_div_q, neg_q, rem_neg_q, div0_q;

  logic        stall_c, accept_c, op_valid;
  logic [31:0] a_mag, b_mag;
  logic [32:0] div_shift, div_diff;
  logic [63:0] prod_res;
  logic [31:0] quo_res, rem_res, res_hi, res_lo;
`ifndef MULDIV_FAST_MUL_EN
  logic [32:0] mul_sum;
`endif

  assign op_valid = (bus.func == `FUNC_MUL) || (bus.func == `FUNC_DIV);
  assign a_mag    = (bus.sign && bus.source_a[31]) ? -bus.source_a : bus.source_a;
  assign b_mag    = (bus.sign && bus.source_b[31]) ? -bus.source_b : bus.source_b;

  // Restoring step: the partial remainder always stays below the divisor, so
  // bit 32 of the trial difference alone tells whether the subtract fits.
  assign div_shift = {acc_q, shf_q[31]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
`ifndef MULDIV_FAST_MUL_EN
  assign mul_sum   = {1'b0, acc_q} + (shf_q[0] ? {1'b0, opnd_q} : 33'd0);
`endif

  // Sign fix-up. Divide by zero returns all-ones regardless of sign; the
  // remainder path already yields source_a there since it keeps the dividend.
  assign prod_res = neg_q ? -{acc_q, shf_q} : {acc_q, shf_q};
  assign quo_res  = div0_q ? 32'hFFFF_FFFF : (neg_q ? -shf_q : shf_q);
  assign rem_res  = rem_neg_q ? -acc_q : acc_q;
  assign res_hi   = is_div_q ? rem_res : prod_res[63:32];
  assign res_lo   = is_div_q ? quo_res : prod_res[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    stall_c  = 1'b0;
    accept_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && op_valid) begin
          accept_c = 1'b1;
          stall_c  = 1'b1;
          state_d  = (bus.func == `FUNC_DIV) ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        stall_c = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
        state_d = S_DONE;
`else
        if (cnt_q == 5'd31) state_d = S_DONE;
`endif
      end
      S_DIV: begin
        stall_c = 1'b1;
        if (cnt_q == 5'd31) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) begin
      state_d  = S_IDLE;
      stall_c  = 1'b0;
      accept_c = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 5'd0;
      opnd_q    <= 32'd0;
      acc_q     <= 32'd0;
      shf_q     <= 32'd0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
    end else if (accept_c) begin
      cnt_q     <= 5'd0;
      acc_q     <= 32'd0;
      is_div_q  <= (bus.func == `FUNC_DIV);
      neg_q     <= bus.sign && (bus.source_a[31] ^ bus.source_b[31]);
      rem_neg_q <= bus.sign && bus.source_a[31];
      div0_q    <= (bus.source_b == 32'd0);
      opnd_q    <= (bus.func == `FUNC_DIV) ? b_mag : a_mag;
      shf_q     <= (bus.func == `FUNC_DIV) ? a_mag : b_mag;
    end else if (state_q == S_DIV) begin
      if (cnt_q != 5'd31) cnt_q <= cnt_q + 5'd1;
      if (!div_diff[32]) begin
        acc_q <= div_diff[31:0];
        shf_q <= {shf_q[30:0], 1'b1};
      end else begin
        acc_q <= div_shift[31:0];
        shf_q <= {shf_q[30:0], 1'b0};
      end
    end else if (state_q == S_MUL) begin
`ifdef MULDIV_FAST_MUL_EN
      {acc_q, shf_q} <= {32'd0, opnd_q} * {32'd0, shf_q};
`else
      if (cnt_q != 5'd31) cnt_q <= cnt_q + 5'd1;
      {acc_q, shf_q} <= {mul_sum, shf_q[31:1]};
`endif
    end
  end

  // HI/LO: commit on leaving DONE (MTHI/MTLO override), MTHI/MTLO in IDLE
  // unless a start is taken in the same cycle. Flush blocks every update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (!bus.flush) begin
      if (state_q == S_DONE) begin
        hi_q <= bus.hi_write ? bus.hi_write_data : res_hi;
        lo_q <= bus.lo_write ? bus.lo_write_data : res_lo;
      end else if (state_q == S_IDLE && !accept_c) begin
        if (bus.hi_write) hi_q <= bus.hi_write_data;
        if (bus.lo_write) lo_q <= bus.lo_write_data;
      end
    end
  end

  assign bus.stall = stall_c;
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule
